// File: rtl/alu181_arbiter.sv
// Round-robin arbiter/sequencer that shares one combinational ALU181 between two
// requesters: IDLE grants and loads operands, ISSUE captures the result, DONE pulses done.
`timescale 1ns/1ps
module alu181_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [5:0] op0,
  input  logic [5:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic       zero,
  output logic       busy,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_m,
  output logic       alu_cn,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_f,
  output logic [7:0] op_count
);

  localparam int DATA_W = 8;
  localparam int OP_W   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last;
  logic              grant;
  logic              win;
  logic              any_req;
  logic              load;
  logic              capture;
  logic              finish;
  logic [OP_W-1:0]   op_win;
  logic [DATA_W-1:0] a_win;
  logic [DATA_W-1:0] b_win;

  // A lone requester always wins; on a tie the one that did not win last time goes.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic lst);
    return (r0 && r1) ? ~lst : r1;
  endfunction

  assign any_req = req0 | req1;
  assign win     = pick_winner(req0, req1, last);
  assign op_win  = win ? op1 : op0;
  assign a_win   = win ? a1  : a0;
  assign b_win   = win ? b1  : b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE:    load    = any_req;
      ISSUE:   capture = 1'b1;
      DONE:    finish  = 1'b1;
      default: ;
    endcase
  end

  // Control: grant bookkeeping, done pulses, busy and the completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 1'b1;
      grant    <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      busy     <= 1'b0;
      op_count <= '0;
    end else begin
      busy  <= (state_nxt != IDLE);
      done0 <= capture && !grant;
      done1 <= capture &&  grant;
      if (load) begin
        last  <= win;
        grant <= win;
      end
      if (finish) op_count <= op_count + 8'd1;
    end
  end

  // Datapath: operands held on the ALU until the next grant, result held until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_m   <= 1'b0;
      alu_cn  <= 1'b0;
      alu_sel <= '0;
      result  <= '0;
      zero    <= 1'b1;
    end else begin
      if (load) begin
        alu_a   <= a_win;
        alu_b   <= b_win;
        alu_m   <= op_win[5];
        alu_cn  <= op_win[4];
        alu_sel <= op_win[3:0];
      end
      if (capture) begin
        result <= alu_f;
        zero   <= (alu_f == '0);
      end
    end
  end

endmodule
